// File: rtl/rgb_pixel_fifo.sv
// Single-clock pixel FIFO in front of the ADV7511 RGB input: valid/ready producer side,
// pop-per-pulse registered output, priming after reset/flush, fill colour on underflow.
module rgb_pixel_fifo #(
  parameter int unsigned          IMG_WIDTH   = 8,
  parameter int unsigned          DEPTH_LOG2  = 11,
  parameter int unsigned          PRIME_LEVEL = 1920,
  parameter logic [IMG_WIDTH-1:0] FILL_R      = '0,
  parameter logic [IMG_WIDTH-1:0] FILL_G      = '0,
  parameter logic [IMG_WIDTH-1:0] FILL_B      = '0
) (
  input  logic                  clk_in,
  input  logic                  resetb,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IMG_WIDTH-1:0]  s_r,
  input  logic [IMG_WIDTH-1:0]  s_g,
  input  logic [IMG_WIDTH-1:0]  s_b,
  input  logic                  rgb_rd_en,
  output logic [IMG_WIDTH-1:0]  r_out,
  output logic [IMG_WIDTH-1:0]  g_out,
  output logic [IMG_WIDTH-1:0]  b_out,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  primed,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt,
  input  logic                  underflow_clr
);

  localparam int unsigned        PW        = 3 * IMG_WIDTH;
  localparam int unsigned        DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PRIME_THR = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0] MSB_ONLY  = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                full, empty, wr_en, pop_en, fill_load, uf_event;

  // Full/empty come from registered pointers only, so s_ready never sees rgb_rd_en.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == MSB_ONLY);
  assign s_ready = !full;
  assign level   = wr_ptr - rd_ptr;
  assign wr_en   = s_valid && !full && !flush;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) state <= ST_FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    primed    = 1'b0;
    pop_en    = 1'b0;
    fill_load = 1'b0;
    uf_event  = 1'b0;
    unique case (state)
      ST_FILL: begin
        if (rgb_rd_en) fill_load = 1'b1;
        if (level >= PRIME_THR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        primed = 1'b1;
        if (rgb_rd_en) begin
          if (empty) begin
            fill_load = 1'b1;
            uf_event  = 1'b1;
          end else begin
            pop_en = 1'b1;
          end
        end
      end
      default: state_nxt = ST_FILL;
    endcase
    if (flush) begin
      state_nxt = ST_FILL;
      pop_en    = 1'b0;
      fill_load = 1'b0;
      uf_event  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_r, s_g, s_b};
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      {r_out, g_out, b_out} <= '0;
    end else if (pop_en) begin
      {r_out, g_out, b_out} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end else if (fill_load) begin
      {r_out, g_out, b_out} <= {FILL_R, FILL_G, FILL_B};
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (underflow_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (uf_event) begin
      underflow <= 1'b1;
      if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// Randomised bench for rgb_pixel_fifo: a queue-based reference model is compared against
// the DUT every cycle, with a few literal expectations pinning the directed scenarios.
module tb_rgb_pixel_fifo;

  localparam logic [23:0] FILL = 24'h123456;

  logic        clk_in = 1'b0;
  logic        resetb = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_r = '0, s_g = '0, s_b = '0;
  logic        rgb_rd_en = 1'b0;
  logic [7:0]  r_out, g_out, b_out;
  logic        flush = 1'b0;
  logic [11:0] level;
  logic        primed, underflow;
  logic [15:0] underflow_cnt;
  logic        underflow_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_pixel_fifo #(
    .IMG_WIDTH(8), .DEPTH_LOG2(11), .PRIME_LEVEL(1920),
    .FILL_R(8'h12), .FILL_G(8'h34), .FILL_B(8'h56)
  ) dut (
    .clk_in(clk_in), .resetb(resetb), .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .rgb_rd_en(rgb_rd_en),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .flush(flush), .level(level),
    .primed(primed), .underflow(underflow), .underflow_cnt(underflow_cnt),
    .underflow_clr(underflow_clr)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: FIFO as a queue, priming as a flag, status as plain counters.
  logic [23:0] q[$];
  logic [23:0] m_out = '0;
  logic        m_primed = 1'b0;
  logic        m_uf = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      q.delete();
      m_out = '0; m_primed = 1'b0; m_uf = 1'b0; m_cnt = 0;
    end else begin
      bit do_uf;
      int pre_size;
      do_uf = 1'b0;
      pre_size = q.size();
      if (flush) begin
        q.delete();
        m_primed = 1'b0;
      end else begin
        if (rgb_rd_en) begin
          if (!m_primed)        m_out = FILL;
          else if (pre_size > 0) m_out = q.pop_front();
          else begin
            m_out = FILL;
            do_uf = 1'b1;
          end
        end
        if (s_valid && pre_size != 2048) q.push_back({s_r, s_g, s_b});
        if (!m_primed && pre_size >= 1920) m_primed = 1'b1;
      end
      if (underflow_clr) begin
        m_uf = 1'b0; m_cnt = 0;
      end else if (do_uf) begin
        m_uf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    check("rgb_out",  {8'h0, r_out, g_out, b_out}, {8'h0, m_out});
    check("level",    {20'h0, level}, q.size());
    check("s_ready",  {31'h0, s_ready}, {31'h0, q.size() != 2048});
    check("primed",   {31'h0, primed}, {31'h0, m_primed});
    check("underflow", {31'h0, underflow}, {31'h0, m_uf});
    check("uf_cnt",   {16'h0, underflow_cnt}, m_cnt);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_pixel(input logic [23:0] p);
    {s_r, s_g, s_b} = p;
  endtask

  logic [23:0] saved_out;

  initial begin
    repeat (3) step();
    check("reset_level", {20'h0, level}, 32'd0);
    check("reset_ready", {31'h0, s_ready}, 32'd1);
    check("reset_rgb",   {8'h0, r_out, g_out, b_out}, 32'd0);
    resetb = 1'b1;
    step();

    // Prime with r=g=b=index[7:0]
    for (int i = 0; i < 1920; i++) begin
      s_valid = 1'b1;
      drive_pixel({3{i[7:0]}});
      step();
    end
    s_valid = 1'b0;
    check("prime_level",  {20'h0, level}, 32'd1920);
    check("prime_early",  {31'h0, primed}, 32'd0);
    step();
    check("primed_rise",  {31'h0, primed}, 32'd1);

    rgb_rd_en = 1'b1;
    repeat (1920) step();
    rgb_rd_en = 1'b0;
    check("drain_level", {20'h0, level}, 32'd0);
    check("drain_last",  {8'h0, r_out, g_out, b_out}, 32'h7f7f7f);
    check("drain_nouf",  {31'h0, underflow}, 32'd0);

    rgb_rd_en = 1'b1;
    step();
    check("uf_fill", {8'h0, r_out, g_out, b_out}, {8'h0, FILL});
    check("uf_flag", {31'h0, underflow}, 32'd1);
    check("uf_cnt1", {16'h0, underflow_cnt}, 32'd1);
    repeat (3) step();
    rgb_rd_en = 1'b0;
    check("uf_cnt4", {16'h0, underflow_cnt}, 32'd4);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    check("clr_cnt", {16'h0, underflow_cnt}, 32'd0);
    rgb_rd_en = 1'b1; underflow_clr = 1'b1;
    step();
    rgb_rd_en = 1'b0; underflow_clr = 1'b0;
    check("clr_beats_uf", {31'h0, underflow}, 32'd0);
    check("clr_beats_cnt", {16'h0, underflow_cnt}, 32'd0);

    // Fill to full, then a pop with s_valid held must not write through
    for (int i = 0; i < 2048; i++) begin
      s_valid = 1'b1;
      drive_pixel(24'($urandom));
      step();
    end
    check("full_level", {20'h0, level}, 32'd2048);
    check("full_ready", {31'h0, s_ready}, 32'd0);
    rgb_rd_en = 1'b1;
    step();
    s_valid = 1'b0;
    rgb_rd_en = 1'b0;
    check("nowt_level", {20'h0, level}, 32'd2047);
    check("nowt_ready", {31'h0, s_ready}, 32'd1);

    rgb_rd_en = 1'b1;
    repeat (1547) step();
    rgb_rd_en = 1'b0;
    check("pre_flush_level", {20'h0, level}, 32'd500);
    saved_out = m_out;
    flush = 1'b1; rgb_rd_en = 1'b1;
    step();
    flush = 1'b0; rgb_rd_en = 1'b0;
    check("flush_level", {20'h0, level}, 32'd0);
    check("flush_state", {31'h0, primed}, 32'd0);
    check("flush_hold",  {8'h0, r_out, g_out, b_out}, {8'h0, saved_out});
    check("flush_nouf",  {16'h0, underflow_cnt}, 32'd0);

    // Randomised traffic in three rate regimes
    for (int seg = 0; seg < 3; seg++) begin
      int wr_pct, rd_pct, len;
      wr_pct = (seg == 0) ? 90 : (seg == 1) ? 50 : 20;
      rd_pct = (seg == 0) ? 10 : (seg == 1) ? 60 : 80;
      len    = (seg == 0) ? 2500 : (seg == 1) ? 2000 : 1500;
      for (int c = 0; c < len; c++) begin
        s_valid       = ($urandom_range(0, 99) < wr_pct);
        rgb_rd_en     = ($urandom_range(0, 99) < rd_pct);
        flush         = ($urandom_range(0, 999) == 0);
        underflow_clr = ($urandom_range(0, 199) == 0);
        drive_pixel(24'($urandom));
        step();
      end
    end
    s_valid = 1'b0; rgb_rd_en = 1'b0; underflow_clr = 1'b0;

    // Mid-stream asynchronous reset at level 1000
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      s_valid = 1'b1;
      drive_pixel(24'($urandom) | 24'h010000);
      step();
    end
    s_valid = 1'b0;
    rgb_rd_en = 1'b1;
    repeat (1000) step();
    rgb_rd_en = 1'b0;
    check("mid_level", {20'h0, level}, 32'd1000);
    check("mid_primed", {31'h0, primed}, 32'd1);
    #3;
    resetb = 1'b0;
    #1;
    check("arst_level",  {20'h0, level}, 32'd0);
    check("arst_rgb",    {8'h0, r_out, g_out, b_out}, 32'd0);
    check("arst_primed", {31'h0, primed}, 32'd0);
    check("arst_ready",  {31'h0, s_ready}, 32'd1);
    repeat (2) step();
    resetb = 1'b1;
    step();
    check("post_ready", {31'h0, s_ready}, 32'd1);
    check("post_level", {20'h0, level}, 32'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
